// File: rtl/arith_pipe.sv
// arith_pipe: pipelined add/sub/pass unit with operand compare, low-bit cut, sticky interrupt and match counter
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   i_in_valid/o_in_ready    operand beat handshake (o_in_ready depends only on output side)
//   i_mode            0: op1+op2, 1: op1-op2, 2: op2+op3, 3: pass op1
//   i_op1/i_op2/i_op3 operands
//   o_out_valid/i_out_ready  result beat handshake
//   o_res             WIDTH+1 bit result (carry/borrow in the top bit)
//   o_compare         op1 == op2 of the same beat
//   o_cut             op1[CUT-1:0] of the same beat
//   i_intr_en/i_intr_clr/o_intr  sticky maskable match interrupt
//   o_match_cnt       saturating count of delivered compare matches
module arith_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int CUT    = 10,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   input  logic [WIDTH-1:0] i_op3,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH:0]   o_res,
   output logic             o_compare,
   output logic [CUT-1:0]   o_cut,
   input  logic             i_intr_en,
   input  logic             i_intr_clr,
   output logic             o_intr,
   output logic [CNT_W-1:0] o_match_cnt
);
   logic [WIDTH:0]   w_res;
   logic             w_stall;
   logic             w_hit;
   logic             r_vld [STAGES];
   logic [WIDTH:0]   r_res [STAGES];
   logic             r_cmp [STAGES];
   logic [CUT-1:0]   r_cut [STAGES];
   logic             r_intr;
   logic [CNT_W-1:0] r_cnt;

   always_comb begin
      w_res = i_mode == 2'd0 ? {1'b0, i_op1} + {1'b0, i_op2} :
              i_mode == 2'd1 ? {1'b0, i_op1} - {1'b0, i_op2} :
              i_mode == 2'd2 ? {1'b0, i_op2} + {1'b0, i_op3} :
                               {1'b0, i_op1};
   end

   // whole pipe moves in lock-step, so a full output with no taker freezes everything
   assign w_stall = o_out_valid && !i_out_ready;
   assign w_hit   = o_out_valid && i_out_ready && o_compare;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            r_vld[s] <= 1'b0;
            r_res[s] <= '0;
            r_cmp[s] <= 1'b0;
            r_cut[s] <= '0;
         end
      end else if (!w_stall) begin
         r_vld[0] <= i_in_valid;
         r_res[0] <= w_res;
         r_cmp[0] <= i_op1 == i_op2;
         r_cut[0] <= i_op1[CUT-1:0];
         for (int s = 1; s < STAGES; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_res[s] <= r_res[s-1];
            r_cmp[s] <= r_cmp[s-1];
            r_cut[s] <= r_cut[s-1];
         end
      end
   end

   // a qualifying set beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_intr <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_intr <= w_hit && i_intr_en ? 1'b1 : i_intr_clr ? 1'b0 : r_intr;
         r_cnt  <= w_hit && r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
      end
   end

   assign o_in_ready  = !w_stall;
   assign o_out_valid = r_vld[STAGES-1];
   assign o_res       = r_res[STAGES-1];
   assign o_compare   = r_cmp[STAGES-1];
   assign o_cut       = r_cut[STAGES-1];
   assign o_intr      = r_intr;
   assign o_match_cnt = r_cnt;
endmodule
